// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, frame shape constants and the baud divisor rule.
// Used by both the transmit buffer and the receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clocks per bit, rounded to nearest so the baud error stays under half a clock per bit.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count; pop data is the head entry, visible combinationally.
// Latency 1 clock push-to-visible; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the current count only, so a same-cycle pop never frees a slot early.
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter; byte accepted at edge k is popped at k+1, tx falls at k+2.
// Backpressure: tx_ready low only while the FIFO is full; frames back-to-back while data is queued.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int CW       = $clog2(BAUD_DIV);
    localparam int BW       = $clog2(DATA_BITS);

    state_t               state;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] fifo_dat;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push_vld;
    logic                 pop_rdy;
    logic                 baud_wrap;

    assign tx_ready  = !fifo_full;
    assign push_vld  = tx_valid && tx_ready;
    assign baud_wrap = (baud_cnt == CW'(BAUD_DIV - 1));
    // Pop from IDLE as soon as data exists, or at the end of a stop bit to chain frames.
    assign pop_rdy   = !fifo_empty && ((state == IDLE) || (state == STOP && baud_wrap));
    assign busy      = (state != IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_vld),
        .push_dat (tx_data),
        .pop      (pop_rdy),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            // tx follows the state one clock late, which keeps every bit exactly BAUD_DIV wide.
            case (state)
                START:   tx <= 1'b0;
                DATA:    tx <= shift[0];
                default: tx <= 1'b1;
            endcase

            if (state == IDLE || baud_wrap) baud_cnt <= '0;
            else                            baud_cnt <= baud_cnt + CW'(1);

            case (state)
                IDLE: begin
                    if (pop_rdy) begin
                        shift <= fifo_dat;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        state   <= DATA;
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        shift <= shift >> 1;
                        if (bit_idx == BW'(DATA_BITS - 1)) state   <= STOP;
                        else                               bit_idx <= bit_idx + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        if (pop_rdy) begin
                            shift <= fifo_dat;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: line decoders score frames against queues of accepted bytes.
// One instance at BAUD_DIV=10 for protocol tests, one at default rates for the loopback.
module tb_uart_tx_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data, tx_data_b;
    logic       tx_valid, tx_valid_b;
    logic       tx_ready, tx_ready_b;
    logic       tx, tx_b;
    logic       busy, busy_b;
    logic [3:0] fifo_count, fifo_count_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rst_epoch = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int start_q[$];

    uart_tx_buf #(.CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count));

    uart_tx_buf dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b), .fifo_count(fifo_count_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic rx_line(input bit which);
        return which ? tx_b : tx;
    endfunction

    // Entered at the first negedge showing the start bit low; samples every bit at its middle.
    task automatic rx_frame(input bit which, input int div, output logic [7:0] b, output logic fok);
        logic s0, sp;
        repeat (div / 2) @(negedge clk);
        s0 = rx_line(which);
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge clk);
            b[i] = rx_line(which);
        end
        repeat (div) @(negedge clk);
        sp = rx_line(which);
        fok = (s0 === 1'b0) && (sp === 1'b1);
    endtask

    task automatic score(input bit which, input logic [7:0] got, input logic fok);
        logic [7:0] want;
        checks++;
        if ((which ? exp_b.size() : exp_a.size()) == 0) begin
            errors++;
            $display("FAIL unexpected_frame line%0d: got %02h expected no frame", which, got);
        end else begin
            want = which ? exp_b.pop_front() : exp_a.pop_front();
            if (got !== want || fok !== 1'b1) begin
                errors++;
                $display("FAIL frame line%0d: got %02h framing_ok=%0b expected %02h framing_ok=1",
                         which, got, fok, want);
            end
        end
    endtask

    initial begin : mon_a
        logic [7:0] b;
        logic fok;
        int ep;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                ep = rst_epoch;
                start_q.push_back(cyc);
                rx_frame(1'b0, 10, b, fok);
                if (ep == rst_epoch) score(1'b0, b, fok);
            end
        end
    end

    initial begin : mon_b
        logic [7:0] b;
        logic fok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_b === 1'b0) begin
                rx_frame(1'b1, 434, b, fok);
                score(1'b1, b, fok);
            end
        end
    end

    // Called just after a negedge; returns at the negedge following the accepting edge.
    task automatic send(input bit which, input logic [7:0] b, output int acc, output bit waited);
        int w;
        w = 0;
        waited = 1'b0;
        acc = -1;
        if (which) begin tx_data_b = b; tx_valid_b = 1'b1; end
        else       begin tx_data   = b; tx_valid   = 1'b1; end
        while (!(which ? tx_ready_b : tx_ready) && w < 5000) begin
            waited = 1'b1;
            @(negedge clk);
            w++;
        end
        if (w >= 5000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout line%0d: got tx_ready=0 expected 1 within 5000 clocks", which);
        end else begin
            acc = cyc + 1;
            if (which) exp_b.push_back(b);
            else       exp_a.push_back(b);
        end
        @(negedge clk);
        if (which) tx_valid_b = 1'b0;
        else       tx_valid   = 1'b0;
    endtask

    task automatic wait_drain(input bit which, input int budget);
        int w;
        w = 0;
        while ((which ? exp_b.size() : exp_a.size()) != 0 && w < budget) begin
            @(negedge clk);
            w++;
        end
        chk(which ? "drain_b" : "drain_a", which ? exp_b.size() : exp_a.size(), 0);
    endtask

    initial begin : stim
        int acc[12];
        int acc0, first_wait, w, f, bad_tx, bad_busy;
        bit waited;
        logic [7:0] burst_byte;
        logic [7:0] lb_bytes[4];

        lb_bytes[0] = 8'h00; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'h5A; lb_bytes[3] = 8'h81;
        rst_n = 1'b0;
        tx_valid = 1'b0; tx_valid_b = 1'b0; tx_data = '0; tx_data_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 1);
        chk("reset_busy", busy, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_ready", tx_ready, 1);
        rst_n = 1'b1;

        // Idle line
        bad_tx = 0; bad_busy = 0;
        repeat (10000) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (busy !== 1'b0) bad_busy++;
        end
        chk("idle_tx_not_high_cycles", bad_tx, 0);
        chk("idle_busy_cycles", bad_busy, 0);

        // Single byte 0x55 with latency and busy timing
        send(1'b0, 8'h55, acc0, waited);
        chk("single_count_n1", fifo_count, 1);
        chk("single_busy_n1", busy, 1);
        chk("single_tx_n1", tx, 1);
        for (int n = 2; n <= 103; n++) begin
            @(negedge clk);
            if (n == 2)   begin chk("single_count_n2", fifo_count, 0); chk("single_tx_n2", tx, 1); end
            if (n == 3)   chk("single_tx_fall_n3", tx, 0);
            if (n == 101) chk("single_busy_n101", busy, 1);
            if (n == 103) begin chk("single_busy_n103", busy, 0); chk("single_count_n103", fifo_count, 0); end
        end
        wait_drain(1'b0, 200);

        // Back-to-back burst 0x00..0x0B, including the full-FIFO push during a pop
        start_q.delete();
        first_wait = -1;
        for (int i = 0; i < 12; i++) begin
            burst_byte = 8'(i);
            send(1'b0, burst_byte, acc[i], waited);
            if (waited && first_wait < 0) first_wait = i;
        end
        chk("burst_accepted_before_block", first_wait, 9);
        chk("full_pop_refused_byte9", acc[9] - acc[0], 102);
        chk("full_pop_refused_byte10", acc[10] - acc[0], 202);
        wait_drain(1'b0, 2000);
        repeat (20) @(negedge clk);
        chk("burst_frames", start_q.size(), 12);
        if (start_q.size() > 0) chk("burst_first_fall", start_q[0], acc[0] + 2);
        for (int i = 1; i < 12; i++)
            if (i < start_q.size()) chk("burst_gap", start_q[i] - start_q[i-1], 100);
        chk("burst_busy_end", busy, 0);

        // Reset during DATA bit 3 of 0xA5 with three bytes queued
        start_q.delete();
        send(1'b0, 8'hA5, acc0, waited);
        send(1'b0, 8'h11, acc0, waited);
        send(1'b0, 8'h22, acc0, waited);
        send(1'b0, 8'h33, acc0, waited);
        chk("rst_queued", fifo_count, 3);
        w = 0;
        while (start_q.size() == 0 && w < 1000) begin @(negedge clk); w++; end
        chk("rst_frame_started", start_q.size(), 1);
        f = (start_q.size() > 0) ? start_q[0] : cyc;
        w = 0;
        while (cyc < f + 45 && w < 1000) begin @(negedge clk); w++; end
        rst_n = 1'b0;
        rst_epoch++;
        exp_a.delete();
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        rst_n = 1'b1;
        bad_tx = 0;
        repeat (600) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
        end
        chk("post_rst_tx_low_cycles", bad_tx, 0);
        chk("post_rst_busy", busy, 0);

        // Loopback at default rates
        for (int i = 0; i < 4; i++) send(1'b1, lb_bytes[i], acc0, waited);
        wait_drain(1'b1, 20000);
        repeat (500) @(negedge clk);
        chk("loop_busy_end", busy_b, 0);
        chk("loop_count_end", fifo_count_b, 0);
        chk("loop_line_idle", tx_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
